// File: rtl/shift_pkg.sv
// Shared types and sizing helpers for the serial feeder.
// Contents: FSM state encoding and the bit-counter width helper.
package shift_pkg;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_e;

  localparam int unsigned SER_WIDTH_DEF = 8;

  // Bit-counter width: enough to index WIDTH bits, never below 1.
  function automatic int unsigned ser_cnt_w(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding register sitting in front of the shifter.
// Ports: clk_i/rst_i (sync, active-high), wr_i/wr_data_i write a word,
//        rd_i frees the entry, full_o flags a stored word, rd_data_o shows it.
module ser_hold_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  output logic             full_o,
  output logic [WIDTH-1:0] rd_data_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Writes only happen when empty and reads only when full, so they never collide.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (wr_i) begin
      full_d = 1'b1;
      data_d = wr_data_i;
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full_o    = full_q;
  assign rd_data_o = data_q;

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out feeder for the downstream shift-register chain.
// Ports: clk_i, rst_i (sync, active-high); in_valid_i/in_data_i/in_ready_o word
//        handshake; en_i bit-rate enable; ser_o serial bit with ser_valid_o,
//        sof_o, eof_o framing; busy_o while shifting or holding a word.
module piso_serializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH      = SER_WIDTH_DEF,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  input  logic             en_i,
  output logic             ser_o,
  output logic             ser_valid_o,
  output logic             sof_o,
  output logic             eof_o,
  output logic             busy_o
);

  localparam int unsigned     CNT_W    = ser_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             ser_q, ser_d;
  logic             ser_valid_q, ser_valid_d;
  logic             sof_q, sof_d;
  logic             eof_q, eof_d;
  logic             busy_q, busy_d;

  logic             hold_full, hold_wr, hold_rd;
  logic [WIDTH-1:0] hold_data;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] load_word;

  // Bit sitting at the output end of a shifter image.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  assign in_ready_o = !hold_full;
  assign accept     = in_valid_i && in_ready_o;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_i      (hold_wr),
    .wr_data_i (in_data_i),
    .rd_i      (hold_rd),
    .full_o    (hold_full),
    .rd_data_o (hold_data)
  );

  // Next-state, shifter, counter and output-flag logic.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    ser_d       = ser_q;
    ser_valid_d = ser_valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    hold_wr     = 1'b0;
    hold_rd     = 1'b0;
    load        = 1'b0;
    load_word   = in_data_i;

    case (state_q)
      SER_IDLE: begin
        // Idle words bypass the hold register straight into the shifter.
        if (accept) begin
          load = 1'b1;
        end
      end
      SER_SHIFT: begin
        // A word arriving exactly at word end is loaded directly, not held.
        hold_wr = accept && !(en_i && (bit_cnt_q == LAST_CNT));
        if (en_i) begin
          if (bit_cnt_q != LAST_CNT) begin
            shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
            ser_d     = out_bit(shreg_d);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            sof_d     = 1'b0;
            eof_d     = (bit_cnt_d == LAST_CNT);
          end else if (hold_full) begin
            hold_rd   = 1'b1;
            load      = 1'b1;
            load_word = hold_data;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_d     = SER_IDLE;
            ser_d       = IDLE_LEVEL;
            ser_valid_d = 1'b0;
            sof_d       = 1'b0;
            eof_d       = 1'b0;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase

    // Start of a fresh word: first bit appears on ser_o next cycle.
    if (load) begin
      state_d     = SER_SHIFT;
      shreg_d     = load_word;
      ser_d       = out_bit(load_word);
      bit_cnt_d   = '0;
      ser_valid_d = 1'b1;
      sof_d       = 1'b1;
      eof_d       = 1'b0;
    end

    busy_d = (state_d == SER_SHIFT) || ((hold_full || hold_wr) && !hold_rd);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SER_IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_q       <= IDLE_LEVEL;
      ser_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      ser_q       <= ser_d;
      ser_valid_q <= ser_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
    end
  end

  assign ser_o       = ser_q;
  assign ser_valid_o = ser_valid_q;
  assign sof_o       = sof_q;
  assign eof_o       = eof_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first/idle-0 instance and an LSB-first/idle-1
// instance share one stimulus stream and are checked every cycle against a
// word-queue model of the handshake and bit stream.
module tb_piso_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         en;

  logic m_ready, m_ser, m_sval, m_sof, m_eof, m_busy;
  logic l_ready, l_ser, l_sval, l_sof, l_eof, l_busy;

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  // Model: words accepted and not yet fully sent; front is in flight.
  logic [W-1:0] mq[$];
  int           mpos = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(m_ready), .en_i(en), .ser_o(m_ser), .ser_valid_o(m_sval),
    .sof_o(m_sof), .eof_o(m_eof), .busy_o(m_busy)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_lsb (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(l_ready), .en_i(en), .ser_o(l_ser), .ser_valid_o(l_sval),
    .sof_o(l_sof), .eof_o(l_eof), .busy_o(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock, update the model from the inputs seen at the edge, compare.
  task automatic step();
    bit           acc;
    bit           vld;
    logic [W-1:0] word;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete();
      mpos = 0;
    end else begin
      acc = in_valid && (mq.size() < 2);
      if (mq.size() > 0 && en) begin
        mpos++;
        if (mpos == W) begin
          void'(mq.pop_front());
          mpos = 0;
        end
      end
      if (acc) mq.push_back(in_data);
    end
    #1;
    vld  = (mq.size() > 0);
    word = vld ? mq[0] : '0;
    check("m_ready", 32'(m_ready), 32'(mq.size() < 2));
    check("m_sval",  32'(m_sval),  32'(vld));
    check("m_ser",   32'(m_ser),   vld ? 32'(word[W-1-mpos]) : 32'(0));
    check("m_sof",   32'(m_sof),   32'(vld && mpos == 0));
    check("m_eof",   32'(m_eof),   32'(vld && mpos == W - 1));
    check("m_busy",  32'(m_busy),  32'(vld));
    check("l_ready", 32'(l_ready), 32'(mq.size() < 2));
    check("l_sval",  32'(l_sval),  32'(vld));
    check("l_ser",   32'(l_ser),   vld ? 32'(word[mpos]) : 32'(1));
    check("l_sof",   32'(l_sof),   32'(vld && mpos == 0));
    check("l_eof",   32'(l_eof),   32'(vld && mpos == W - 1));
    check("l_busy",  32'(l_busy),  32'(vld));
  endtask

  task automatic offer(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    logic [W-1:0] seq;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; en = 1'b1;
    @(negedge clk);
    step(); step();
    check("rst_ser_idle0", 32'(m_ser), 32'(0));
    check("rst_ready", 32'(m_ready), 32'(1));
    rst = 1'b0;
    idle_cycles(2);

    // Single word A5, first-bit latency one cycle.
    offer(8'hA5);
    seq = '0;
    for (int i = 0; i < W; i++) begin
      seq = {seq[W-2:0], m_ser};
      step();
    end
    check("a5_msb_seq", 32'(seq), 32'hA5);
    check("a5_after_sval", 32'(m_sval), 32'(0));
    idle_cycles(2);

    // Back-to-back A5 then 3C, no bubble.
    offer(8'hA5);
    offer(8'h3C);
    idle_cycles(20);

    // Enable gaps freeze the stream.
    offer(8'hA5);
    for (int c = 1; c <= 14; c++) begin
      en = !(c >= 4 && c <= 6);
      step();
    end
    en = 1'b1;
    idle_cycles(2);

    // LSB-first instance: 01 sends a single leading 1.
    offer(8'h01);
    seq = '0;
    for (int i = 0; i < W; i++) begin
      seq = {seq[W-2:0], l_ser};
      step();
    end
    check("01_lsb_seq", 32'(seq), 32'h80);
    idle_cycles(2);

    // Reset mid-word with a word held, then a clean FF.
    offer(8'hA5);
    offer(8'h3C);
    idle_cycles(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 32'(m_busy), 32'(0));
    check("midrst_ready", 32'(m_ready), 32'(1));
    offer(8'hFF);
    idle_cycles(12);

    // Randomized traffic with enable gaps and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      in_data  = W'($urandom);
      en       = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; en = 1'b1;
    idle_cycles(24);
    check("drain_busy", 32'(m_busy), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
